// File: rtl/instr_mem_access.sv
// instr_mem_access: memory-access pipeline stage between execute and write-back.
// Loads and stores run one req/ack transaction on the data-memory port while
// the upstream pipeline is stalled. Non-memory and illegal memory instructions
// retire one cycle after they are accepted.
//
// Handshake: dmem_req rises on the clock edge that accepts a legal memory op.
// dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata then stay stable until
// the cycle in which dmem_ack=1. That cycle also samples dmem_rdata and retires
// the instruction, and dmem_req falls on the following edge. dmem_ack is only
// looked at while a request is outstanding.
module instr_mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        valid_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] result_out,
  output logic        mem_err_out
);

  localparam int XLEN = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [XLEN-1:0]   op_instr_q, op_instr_d;
  logic [XLEN-1:0]   op_alu_q, op_alu_d;
  logic [2:0]        op_f3_q, op_f3_d;
  logic              valid_out_q, valid_out_d;
  logic [XLEN-1:0]   instr_out_q, instr_out_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              err_q, err_d;
  logic              stall_c;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_load, is_store, is_mem;
  logic              f3_ok, misaligned, mem_ok;
  logic [3:0]        be_calc;
  logic [XLEN-1:0]   wdata_calc;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   load_data;

  // Decode the incoming instruction: memory-op class, legality, byte enables and lane data.
  always_comb begin
    opcode     = instruction_in[6:0];
    funct3     = instruction_in[14:12];
    is_load    = (opcode == OP_LOAD);
    is_store   = (opcode == OP_STORE);
    is_mem     = valid_in && (is_load || is_store);
    f3_ok      = 1'b0;
    if (is_load)  f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (is_store) f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = store_data_in;
    // funct3[1:0] is the access size for both loads and stores.
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << alu_in[1:0];
        wdata_calc = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        misaligned = alu_in[0];
        be_calc    = alu_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data_in[15:0]}};
      end
      2'b10: begin
        misaligned = (alu_in[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b0;
      end
    endcase
    mem_ok = is_mem && f3_ok && !misaligned;
  end

  // Extract and extend the addressed byte/half of the returned word using the latched op.
  always_comb begin
    case (op_alu_q[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = op_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state and output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    op_instr_d   = op_instr_q;
    op_alu_d     = op_alu_q;
    op_f3_d      = op_f3_q;
    valid_out_d  = 1'b0;
    instr_out_d  = instr_out_q;
    result_d     = result_q;
    err_d        = err_q;
    stall_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!halt && valid_in) begin
          if (mem_ok) begin
            stall_c      = 1'b1;
            state_d      = BUSY;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {alu_in[31:2], 2'b00};
            dmem_be_d    = be_calc;
            dmem_wdata_d = is_store ? wdata_calc : 32'd0;
            op_instr_d   = instruction_in;
            op_alu_d     = alu_in;
            op_f3_d      = funct3;
          end else begin
            // Non-memory op, or a memory op rejected as illegal: retire directly.
            valid_out_d = 1'b1;
            instr_out_d = instruction_in;
            result_d    = alu_in;
            err_d       = is_mem;
          end
        end
      end
      BUSY: begin
        stall_c = !dmem_ack;
        if (dmem_ack) begin
          state_d     = IDLE;
          dmem_req_d  = 1'b0;
          valid_out_d = 1'b1;
          instr_out_d = op_instr_q;
          result_d    = dmem_we_q ? op_alu_q : load_data;
          err_d       = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      op_instr_q   <= '0;
      op_alu_q     <= '0;
      op_f3_q      <= '0;
      valid_out_q  <= 1'b0;
      instr_out_q  <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      op_instr_q   <= op_instr_d;
      op_alu_q     <= op_alu_d;
      op_f3_q      <= op_f3_d;
      valid_out_q  <= valid_out_d;
      instr_out_q  <= instr_out_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  assign stall           = rst && stall_c;
  assign dmem_req        = dmem_req_q;
  assign dmem_we         = dmem_we_q;
  assign dmem_addr       = dmem_addr_q;
  assign dmem_be         = dmem_be_q;
  assign dmem_wdata      = dmem_wdata_q;
  assign valid_out       = valid_out_q;
  assign instruction_out = instr_out_q;
  assign result_out      = result_q;
  assign mem_err_out     = err_q;

endmodule

// File: tb/tb_instr_mem_access.sv
// Bench for instr_mem_access: directed instructions, a scoreboard queue of
// expected retirements {cycle, instruction, result, err}, and a monitor that
// pops and compares whenever valid_out is high.
module tb_instr_mem_access;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        valid_in;
  logic [31:0] instruction_in;
  logic [31:0] alu_in;
  logic [31:0] store_data_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] result_out;
  logic        mem_err_out;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  // {exp_cycle[15:0], instruction[31:0], result[31:0], err}
  logic [80:0] exp_q[$];

  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_SX4 = 32'h0000_4023;
  localparam logic [31:0] I_LB  = 32'h0000_0003;
  localparam logic [31:0] I_LH  = 32'h0000_1003;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_LX3 = 32'h0000_3003;
  localparam logic [31:0] I_LBU = 32'h0000_4003;
  localparam logic [31:0] I_LHU = 32'h0000_5003;

  instr_mem_access dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .valid_in        (valid_in),
    .instruction_in  (instruction_in),
    .alu_in          (alu_in),
    .store_data_in   (store_data_in),
    .stall           (stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .valid_out       (valid_out),
    .instruction_out (instruction_out),
    .result_out      (result_out),
    .mem_err_out     (mem_err_out)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one instruction; memory ops are acked k cycles after the request rises.
  task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd,
                       input logic mem_ok, input int k, input logic [31:0] rdata,
                       input logic [31:0] exp_res, input logic exp_err,
                       input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    logic [15:0] ec;
    @(negedge clk);
    valid_in = 1'b1; instruction_in = instr; alu_in = alu; store_data_in = sd; halt = 1'b0;
    #1;
    chk("stall_at_accept", {31'd0, stall}, {31'd0, mem_ok});
    ec = 16'(cyc + (mem_ok ? k + 1 : 1));
    exp_q.push_back({ec, instr, exp_res, exp_err});
    if (mem_ok) begin
      for (int i = 1; i <= k; i++) begin
        @(negedge clk);
        chk("dmem_req_busy", {31'd0, dmem_req}, 32'd1);
        if (i == 1) begin
          chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
          chk("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
          chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
          if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
        end
        if (i < k) begin
          #1 chk("stall_busy", {31'd0, stall}, 32'd1);
        end else begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
          #1 chk("stall_on_ack", {31'd0, stall}, 32'd0);
        end
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'd0; valid_in = 1'b0;
      chk("dmem_req_dropped", {31'd0, dmem_req}, 32'd0);
    end else begin
      @(negedge clk);
      valid_in = 1'b0;
      chk("no_dmem_req", {31'd0, dmem_req}, 32'd0);
    end
  endtask

  // Monitor: every retirement must match the head of the expected queue.
  initial begin : monitor
    logic [80:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_retire: instr %h result %h at cycle %0d", instruction_out, result_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("retire_cycle", 32'(cyc), {16'd0, e[80:65]});
          chk("retire_instr", instruction_out, e[64:33]);
          chk("retire_result", result_out, e[32:1]);
          chk("retire_err", {31'd0, mem_err_out}, {31'd0, e[0]});
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b0; halt = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    // Present a legal store during reset: stall must stay low.
    valid_in = 1'b1; instruction_in = I_SB; alu_in = 32'h103; store_data_in = 32'hAB;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_instr_out", instruction_out, 32'd0);
    chk("rst_result_out", result_out, 32'd0);
    chk("rst_err_out", {31'd0, mem_err_out}, 32'd0);
    rst = 1'b1; valid_in = 1'b0;

    issue(I_ADD, 32'h0000_1234, 32'h0, 1'b0, 0, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 4'h0, 32'h0);
    issue(I_SB,  32'h103, 32'h0000_00AB, 1'b1, 3, 32'h0, 32'h103, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB);
    issue(I_LB,  32'h102, 32'h0, 1'b1, 1, 32'h0080_0000, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b0100, 32'h0);
    issue(I_LBU, 32'h102, 32'h0, 1'b1, 1, 32'h0080_0000, 32'h0000_0080, 1'b0, 1'b0, 4'b0100, 32'h0);
    issue(I_LW,  32'h202, 32'h0, 1'b0, 0, 32'h0, 32'h202, 1'b1, 1'b0, 4'h0, 32'h0);
    issue(I_SH,  32'h102, 32'h1234_BEEF, 1'b1, 2, 32'h0, 32'h102, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    issue(I_LH,  32'h102, 32'h0, 1'b1, 2, 32'h8001_7777, 32'hFFFF_8001, 1'b0, 1'b0, 4'b1100, 32'h0);
    issue(I_LHU, 32'h100, 32'h0, 1'b1, 1, 32'h1234_9ABC, 32'h0000_9ABC, 1'b0, 1'b0, 4'b0011, 32'h0);
    issue(I_LW,  32'h200, 32'h0, 1'b1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0);
    issue(I_SW,  32'h204, 32'hCAFE_F00D, 1'b1, 1, 32'h0, 32'h204, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D);
    issue(I_LX3, 32'h300, 32'h0, 1'b0, 0, 32'h0, 32'h300, 1'b1, 1'b0, 4'h0, 32'h0);
    issue(I_SX4, 32'h304, 32'h0, 1'b0, 0, 32'h0, 32'h304, 1'b1, 1'b0, 4'h0, 32'h0);
    issue(I_SH,  32'h101, 32'h0, 1'b0, 0, 32'h0, 32'h101, 1'b1, 1'b0, 4'h0, 32'h0);

    // Halt in IDLE: valid ADD must not be accepted; outputs hold.
    @(negedge clk);
    valid_in = 1'b1; instruction_in = I_ADD; alu_in = 32'h5555; halt = 1'b1;
    repeat (2) @(negedge clk);
    chk("halt_no_req", {31'd0, dmem_req}, 32'd0);
    chk("halt_result_hold", result_out, 32'h101);
    valid_in = 1'b0; halt = 1'b0;

    // Ack outside BUSY is ignored (monitor flags any retirement).
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_no_req", {31'd0, dmem_req}, 32'd0);

    // Reset mid-BUSY with halt asserted: transaction abandoned.
    @(negedge clk);
    valid_in = 1'b1; instruction_in = I_LW; alu_in = 32'h200;
    @(negedge clk);
    chk("abort_req_up", {31'd0, dmem_req}, 32'd1);
    halt = 1'b1;
    @(negedge clk);
    chk("abort_halt_keeps_busy", {31'd0, dmem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("abort_valid_out", {31'd0, valid_out}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    halt = 1'b0;
    issue(I_ADD, 32'hA5A5_0001, 32'h0, 1'b0, 0, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0, 4'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_mem_access.md
# instr_mem_access

Memory-access pipeline stage placed directly downstream of the execute stage. It takes the executed instruction, effective address (ALU result) and store data, runs a req/ack transaction on the data-memory port for loads and stores, formats load data, and registers the result toward write-back. Non-memory instructions pass through in one cycle. While a memory transaction is outstanding, the stage stalls the upstream pipeline.

## Interface
- No parameters; datapath width fixed at 32 bits (`XLEN`).
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- halt  in  1  global pipeline halt
- valid_in  in  1  instruction_in/alu_in/store_data_in are a real instruction, not a bubble
- instruction_in  in  32  instruction from execute
- alu_in  in  32  ALU result; effective byte address for load/store
- store_data_in  in  32  store data from execute; low byte/half significant for SB/SH
- stall  out  1  combinational; upstream holds its outputs while high
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write (store), 0 = read (load)
- dmem_addr  out  32  word address {alu_in[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read data, valid in the cycle dmem_ack=1
- dmem_ack  in  1  one-cycle completion pulse
- valid_out  out  1  one-cycle pulse per retired instruction
- instruction_out  out  32  retired instruction
- result_out  out  32  formatted load data, or alu_in for all other instructions
- mem_err_out  out  1  misaligned access or unsupported funct3 on LOAD/STORE

## Operation
- Memory op: opcode LOAD 7'b0000011 or STORE 7'b0100011 with valid_in=1.
- FSM states: IDLE and BUSY.
- IDLE, halt=1: nothing accepted; valid_out=0 next cycle; other outputs hold.
- IDLE, valid non-memory op: captured at the edge. Next cycle valid_out=1, result_out=alu_in, mem_err_out=0. stall=0.
- IDLE, valid memory op, legal and aligned: stall=1. At the edge, latch the op, address, be, wdata and funct3, set dmem_req=1, and go to BUSY.
- IDLE, valid memory op, illegal: no request. Retired next cycle with valid_out=1, mem_err_out=1 and result_out=alu_in. stall=0.
  - Misaligned: SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]≠0.
  - Unsupported funct3: loads other than 000/001/010/100/101; stores other than 000/001/010.
- BUSY: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable. instruction_in is ignored. stall=!dmem_ack.
- BUSY with dmem_ack=1: at the edge, dmem_req→0, go to IDLE, valid_out=1 and result_out=formatted data. halt does not abort BUSY.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: addr[1]?4'b1100:4'b0011.
  - SW/LW: 4'b1111.
- Store data: SB replicates store_data_in[7:0] into all 4 lanes. SH replicates [15:0] into both halves. SW passes the word through.
- Loads: select the byte or half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word. Store results are alu_in.

## Timing
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, valid_out=0, instruction_out=0, result_out=0, mem_err_out=0.
- stall is combinational and is 0 while rst=0.
- Non-memory or illegal op: latency 1 cycle.
- Memory op presented in cycle N:
  - dmem_req=1 from cycle N+1.
  - dmem_ack at cycle N+k (k≥1) gives valid_out=1 in cycle N+k+1.
  - Minimum latency is 2 cycles.
- dmem_ack outside BUSY is ignored.
- At most one outstanding request.
- The next instruction is accepted in the cycle after retirement, so back-to-back memory ops give one request every ack+1 cycles.
- Reset asserted mid-BUSY: dmem_req drops immediately and the transaction is abandoned. The memory side must discard it.

## Test plan
- ADD, alu_in=0x0000_1234, valid_in=1 → next cycle valid_out=1, result_out=0x0000_1234, stall never high, dmem_req=0.
- SB to addr 0x103, store_data_in=0xAB, ack 3 cycles after req → dmem_be=4'b1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, dmem_we=1.
  - stall high for 3 cycles.
  - valid_out one cycle after ack.
- LB from 0x102 with dmem_rdata=0x0080_0000, ack immediate → result_out=0xFFFF_FF80.
  - Same with LBU → 0x0000_0080.
- LW at 0x202 → no dmem_req, next cycle valid_out=1, mem_err_out=1.
- LW in BUSY with halt asserted and rst pulsed low before ack → dmem_req=0 immediately, valid_out=0, state IDLE.
  - The next ADD retires normally after rst rises and halt clears.
